// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-prediction blocks.
package bp_pkg;

  localparam logic [31:0] PC_INC         = 32'd4;
  localparam logic [31:0] DELAY_SLOT_OFS = 32'd8;

  // Direction part of an in-flight history entry; the owner adds the table index.
  typedef struct packed {
    logic pred_l;
    logic pred_g;
    logic final_p;
  } hist_pred_t;

  function automatic int unsigned cnt_reset_val(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/tournament_chooser_if.sv
// Fetch/decode side signals of the tournament chooser: master drives, slave is the chooser.
interface tournament_chooser_if;
  logic        STALL;
  logic [31:0] IF_PC;
  logic        IF_Valid;
  logic        Pred_L;
  logic        Pred_G;
  logic        Hit_BTB;
  logic [31:0] Alt_PC_BTB;
  logic        ID_Valid;
  logic [31:0] ID_PC;
  logic        Is_Branch;
  logic        Is_Taken;
  logic [31:0] Alt_PC_ID;
  logic        flush;
  logic        request_alt_pc;
  logic [31:0] alt_address;
  logic        Pred_Final;
  logic        hist_overflow;
  logic [31:0] miss_count;
  logic [31:0] branch_count;

  modport master (
    output STALL, IF_PC, IF_Valid, Pred_L, Pred_G, Hit_BTB, Alt_PC_BTB,
           ID_Valid, ID_PC, Is_Branch, Is_Taken, Alt_PC_ID,
    input  flush, request_alt_pc, alt_address, Pred_Final, hist_overflow,
           miss_count, branch_count
  );

  modport slave (
    input  STALL, IF_PC, IF_Valid, Pred_L, Pred_G, Hit_BTB, Alt_PC_BTB,
           ID_Valid, ID_PC, Is_Branch, Is_Taken, Alt_PC_ID,
    output flush, request_alt_pc, alt_address, Pred_Final, hist_overflow,
           miss_count, branch_count
  );
endinterface

// File: rtl/chooser_table.sv
// PC-indexed saturating chooser counters: one combinational read port, one update port.
module chooser_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 10,
  parameter int CNT_BITS = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_sel_o,
  input  logic                upd_en_i,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_inc_i
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(cnt_reset_val(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [CNT_BITS-1:0] upd_d;

  // Reads see the pre-update value, so a same-cycle update is invisible to fetch.
  assign rd_sel_o = cnt_q[rd_idx_i][CNT_BITS-1];

  always_comb begin
    upd_d = cnt_q[upd_idx_i];
    if (upd_inc_i) begin
      if (cnt_q[upd_idx_i] != CNT_MAX) upd_d = cnt_q[upd_idx_i] + CNT_ONE;
    end else begin
      if (cnt_q[upd_idx_i] != '0) upd_d = cnt_q[upd_idx_i] - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RST;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_d;
    end
  end
endmodule

// File: rtl/tournament_chooser.sv
// Tournament chooser with in-flight history FIFO, mispredict redirect and chooser training.
// Optional CHOOSER_STATS_EN builds saturating mispredict/branch counters.
module tournament_chooser
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 10,
  parameter int CNT_BITS = 2,
  parameter int DEPTH    = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  tournament_chooser_if.slave bus
);
  localparam int PTR_BITS = $clog2(DEPTH);

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    hist_pred_t          pred;
  } hist_entry_t;

  hist_entry_t         fifo_q [DEPTH];
  hist_entry_t         head_s, new_s;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]   occ_q, occ_d;
  logic [IDX_BITS-1:0] if_idx_s;
  logic sel_s, final_s, empty_s, full_s, pop_s, brpop_s, train_s, mispredict_s;
  logic push_req_s, push_s, drop_s;
  logic        flush_q, flush_d, req_q, req_d, pred_q, pred_d, ovf_q, ovf_d;
  logic [31:0] alt_q, alt_d;

  assign if_idx_s     = bus.IF_PC[IDX_BITS+1:2];
  assign final_s      = sel_s ? bus.Pred_G : bus.Pred_L;
  assign new_s        = '{idx: if_idx_s, pred: '{pred_l: bus.Pred_L, pred_g: bus.Pred_G, final_p: final_s}};
  assign head_s       = fifo_q[rd_ptr_q];
  assign empty_s      = (occ_q == '0);
  assign full_s       = (occ_q == (PTR_BITS+1)'(DEPTH));
  assign pop_s        = !bus.STALL && bus.ID_Valid && !empty_s;
  assign brpop_s      = pop_s && bus.Is_Branch;
  assign train_s      = brpop_s && (head_s.pred.pred_l != head_s.pred.pred_g);
  assign mispredict_s = brpop_s && (head_s.pred.final_p != bus.Is_Taken);
  assign push_req_s   = !bus.STALL && bus.IF_Valid && !mispredict_s;
  // A full FIFO still accepts a push when the oldest entry leaves in the same cycle.
  assign push_s       = push_req_s && (!full_s || pop_s);
  assign drop_s       = push_req_s && full_s && !pop_s;

  chooser_table #(.IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) u_table (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_idx_i  (if_idx_s),
    .rd_sel_o  (sel_s),
    .upd_en_i  (train_s),
    .upd_idx_i (head_s.idx),
    .upd_inc_i (head_s.pred.pred_g == bus.Is_Taken)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (mispredict_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + (PTR_BITS+1)'(1);
        2'b01:   occ_d = occ_q - (PTR_BITS+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_s) fifo_q[wr_ptr_q] <= new_s;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_comb begin
    flush_d = flush_q;
    req_d   = req_q;
    alt_d   = alt_q;
    pred_d  = pred_q;
    ovf_d   = ovf_q | drop_s;
    if (mispredict_s) begin
      flush_d = 1'b1;
      req_d   = 1'b1;
      alt_d   = bus.Is_Taken ? bus.Alt_PC_ID : bus.ID_PC + DELAY_SLOT_OFS;
    end else if (push_req_s) begin
      flush_d = 1'b0;
      req_d   = final_s & bus.Hit_BTB;
      alt_d   = (final_s & bus.Hit_BTB) ? bus.Alt_PC_BTB : bus.IF_PC + PC_INC;
      pred_d  = final_s;
    end else if (!bus.STALL) begin
      flush_d = 1'b0;
      req_d   = 1'b0;
    end else begin
      flush_d = flush_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      alt_q   <= 32'd0;
      pred_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      flush_q <= flush_d;
      req_q   <= req_d;
      alt_q   <= alt_d;
      pred_q  <= pred_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.flush          = flush_q;
  assign bus.request_alt_pc = req_q;
  assign bus.alt_address    = alt_q;
  assign bus.Pred_Final     = pred_q;
  assign bus.hist_overflow  = ovf_q;

`ifdef CHOOSER_STATS_EN
  logic [31:0] miss_q, miss_d, branch_q, branch_d;

  always_comb begin
    miss_d   = miss_q;
    branch_d = branch_q;
    if (mispredict_s && (miss_q != 32'hFFFF_FFFF)) miss_d = miss_q + 32'd1;
    if (brpop_s && (branch_q != 32'hFFFF_FFFF)) branch_d = branch_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      miss_q   <= 32'd0;
      branch_q <= 32'd0;
    end else begin
      miss_q   <= miss_d;
      branch_q <= branch_d;
    end
  end

  assign bus.miss_count   = miss_q;
  assign bus.branch_count = branch_q;
`else
  assign bus.miss_count   = 32'd0;
  assign bus.branch_count = 32'd0;
`endif
endmodule

// File: tb/tb_tournament_chooser.sv
// Directed bench for tournament_chooser (IDX_BITS=10, CNT_BITS=2, DEPTH=8).
module tb_tournament_chooser;
`ifdef CHOOSER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [9:0] pat_v;

  always #5 CLK = ~CLK;

  tournament_chooser_if bus();

  tournament_chooser #(.IDX_BITS(10), .CNT_BITS(2), .DEPTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_if(input logic v, input logic [31:0] pc, input logic l, input logic g,
                        input logic hit, input logic [31:0] alt);
    bus.IF_Valid = v; bus.IF_PC = pc; bus.Pred_L = l; bus.Pred_G = g;
    bus.Hit_BTB = hit; bus.Alt_PC_BTB = alt;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] alt);
    bus.ID_Valid = v; bus.ID_PC = pc; bus.Is_Branch = br; bus.Is_Taken = tk; bus.Alt_PC_ID = alt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    bus.IF_Valid = 1'b0;
    bus.ID_Valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    bus.STALL = 1'b0;
    set_if(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    set_id(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_flush", 32'(bus.flush), 32'd0);
    check_eq("rst_req", 32'(bus.request_alt_pc), 32'd0);
    check_eq("rst_alt", bus.alt_address, 32'd0);
    check_eq("rst_pred", 32'(bus.Pred_Final), 32'd0);
    check_eq("rst_ovf", 32'(bus.hist_overflow), 32'd0);
    check_eq("rst_miss", bus.miss_count, 32'd0);
    check_eq("rst_branch", bus.branch_count, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Weakly-local counter: final follows L, taken with BTB hit
    set_if(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200); tick();
    check_eq("t1_pred", 32'(bus.Pred_Final), 32'd1);
    check_eq("t1_req", 32'(bus.request_alt_pc), 32'd1);
    check_eq("t1_alt", bus.alt_address, 32'h200);
    check_eq("t1_flush", 32'(bus.flush), 32'd0);
    set_id(1'b1, 32'h100, 1'b0, 1'b0, 32'd0); tick();
    check_eq("drain_flush", 32'(bus.flush), 32'd0);
    check_eq("drain_req", 32'(bus.request_alt_pc), 32'd0);

    // L=0,G=1 at counter 1 -> predicts not-taken, fall-through PC+4
    set_if(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200); tick();
    check_eq("t2_pred", 32'(bus.Pred_Final), 32'd0);
    check_eq("t2_req", 32'(bus.request_alt_pc), 32'd0);
    check_eq("t2_alt", bus.alt_address, 32'h104);
    set_id(1'b1, 32'h100, 1'b1, 1'b1, 32'h300); tick();
    check_eq("t2_mp_flush", 32'(bus.flush), 32'd1);
    check_eq("t2_mp_req", 32'(bus.request_alt_pc), 32'd1);
    check_eq("t2_mp_alt", bus.alt_address, 32'h300);
    set_id(1'b1, 32'h100, 1'b1, 1'b0, 32'd0); tick();
    check_eq("empty_pop_flush", 32'(bus.flush), 32'd0);

    // Counter now 2 -> global; two correct pops push it to 3 and hold it there
    for (int r = 0; r < 2; r++) begin
      set_if(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200); tick();
      check_eq("rep_pred", 32'(bus.Pred_Final), 32'd1);
      check_eq("rep_alt", bus.alt_address, 32'h200);
      set_id(1'b1, 32'h100, 1'b1, 1'b1, 32'h300); tick();
      check_eq("rep_flush", 32'(bus.flush), 32'd0);
    end
    // One decrement from saturated 3 must still choose global
    set_if(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200); tick();
    set_id(1'b1, 32'h100, 1'b1, 1'b0, 32'h300); tick();
    check_eq("dec_flush", 32'(bus.flush), 32'd1);
    check_eq("dec_alt", bus.alt_address, 32'h108);
    set_if(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h200); tick();
    check_eq("sat_pred", 32'(bus.Pred_Final), 32'd1);
    check_eq("sat_alt", bus.alt_address, 32'h104);
    set_id(1'b1, 32'h100, 1'b0, 1'b0, 32'd0); tick();

    // Not-taken mispredict at 0x400 with a same-cycle push that must be discarded
    set_if(1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 32'h500); tick();
    check_eq("nt_push_alt", bus.alt_address, 32'h500);
    set_id(1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
    set_if(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0); tick();
    check_eq("nt_flush", 32'(bus.flush), 32'd1);
    check_eq("nt_req", 32'(bus.request_alt_pc), 32'd1);
    check_eq("nt_alt", bus.alt_address, 32'h408);
    check_eq("nt_pred_hold", 32'(bus.Pred_Final), 32'd1);
    set_id(1'b1, 32'h800, 1'b1, 1'b1, 32'h0); tick();
    check_eq("nt_discard", 32'(bus.flush), 32'd0);

    // STALL holds outputs and blocks the push
    bus.STALL = 1'b1;
    set_if(1'b1, 32'hA00, 1'b0, 1'b0, 1'b1, 32'hB00); tick();
    check_eq("stall_pred", 32'(bus.Pred_Final), 32'd1);
    check_eq("stall_alt", bus.alt_address, 32'h408);
    bus.STALL = 1'b0;
    set_id(1'b1, 32'hA00, 1'b1, 1'b1, 32'h0); tick();
    check_eq("stall_nopush", 32'(bus.flush), 32'd0);
    check_eq("acc_branch", bus.branch_count, STATS ? 32'd5 : 32'd0);
    check_eq("acc_miss", bus.miss_count, STATS ? 32'd3 : 32'd0);

    // Asynchronous reset mid-operation
    set_if(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200); tick();
    check_eq("pre_rst_pred", 32'(bus.Pred_Final), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check_eq("async_rst_pred", 32'(bus.Pred_Final), 32'd0);
    check_eq("async_rst_alt", bus.alt_address, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    set_if(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h200); tick();
    check_eq("post_rst_pred", 32'(bus.Pred_Final), 32'd0);
    check_eq("post_rst_alt", bus.alt_address, 32'h104);
    set_id(1'b1, 32'h100, 1'b1, 1'b0, 32'h0); tick();
    check_eq("post_rst_fifo", 32'(bus.flush), 32'd0);
    // Stats: 3 branches, 2 mispredicts since reset
    set_if(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    set_id(1'b1, 32'h200, 1'b1, 1'b0, 32'h0); tick();
    set_if(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0); tick();
    set_id(1'b1, 32'h200, 1'b1, 1'b1, 32'h900); tick();
    check_eq("st_alt", bus.alt_address, 32'h900);
    check_eq("st_branch", bus.branch_count, STATS ? 32'd3 : 32'd0);
    check_eq("st_miss", bus.miss_count, STATS ? 32'd2 : 32'd0);

    // Overflow: 9 pushes into 8 entries, then push+pop on full, then drain in order
    do_reset();
    pat_v = 10'b0101011001;
    for (int i = 0; i < 9; i++) begin
      set_if(1'b1, 32'h1000 + 32'(i * 4), pat_v[i], pat_v[i], 1'b0, 32'h0); tick();
      if (i == 7) check_eq("ovf_before", 32'(bus.hist_overflow), 32'd0);
    end
    check_eq("ovf_set", 32'(bus.hist_overflow), 32'd1);
    set_if(1'b1, 32'h1024, pat_v[9], pat_v[9], 1'b0, 32'h0);
    set_id(1'b1, 32'h1000, 1'b1, pat_v[0], 32'h0); tick();
    check_eq("full_pp_flush", 32'(bus.flush), 32'd0);
    for (int i = 1; i < 8; i++) begin
      set_id(1'b1, 32'h1000 + 32'(i * 4), 1'b1, pat_v[i], 32'h0); tick();
      check_eq("order_flush", 32'(bus.flush), 32'd0);
    end
    set_id(1'b1, 32'h1024, 1'b1, pat_v[9], 32'h0); tick();
    check_eq("order_last", 32'(bus.flush), 32'd0);
    set_id(1'b1, 32'h1028, 1'b1, ~pat_v[9], 32'h0); tick();
    check_eq("drained", 32'(bus.flush), 32'd0);
    check_eq("ovf_sticky", 32'(bus.hist_overflow), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
